// File: rtl/lenet_xwyf_pkg.sv
// Purpose: shared types and defaults for the LeNet XWYF unsigned divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lenet_xwyf_pkg;

  localparam int ZW_DEF   = 16;
  localparam int YW_DEF   = 8;
  localparam int CNT_W_DEF = $clog2(ZW_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-step counter width; never narrower than one bit.
  function automatic int cnt_width(input int zw);
    return (zw > 1) ? $clog2(zw) : 1;
  endfunction

endpackage

// File: rtl/lenet_xwyf_div_step.sv
// Purpose: one restoring-division step (shift in a dividend bit, trial-subtract the divisor).
// Latency: combinational.
// Backpressure: none; the caller sequences the steps.
module lenet_xwyf_div_step
  import lenet_xwyf_pkg::*;
#(
  parameter int YW = YW_DEF
) (
  input  logic [YW:0]   rem_in,
  input  logic          bit_in,
  input  logic [YW-1:0] y,
  output logic [YW:0]   rem_out,
  output logic          q_bit
);

  // The incoming remainder is always below y, so the top bit of p is zero in
  // practice; keeping the full width makes the compare exact regardless.
  logic [YW+1:0] p;
  logic [YW+1:0] y_ext;

  // Trial subtraction: keep the difference when it does not underflow.
  always_comb begin
    p       = {rem_in, bit_in};
    y_ext   = {2'b00, y};
    q_bit   = (p >= y_ext);
    rem_out = q_bit ? (YW+1)'(p - y_ext) : p[YW:0];
  end

endmodule

// File: rtl/lenet_xwyf_udiv.sv
// Purpose: sequential unsigned radix-2 restoring divider, q = z / y, r = z % y, dz flag on y==0.
// Latency: ZW cycles of stepping after acceptance (y!=0), one cycle for y==0.
// Backpressure: result held in DONE until out_ready; no new operands accepted until then.
module lenet_xwyf_udiv
  import lenet_xwyf_pkg::*;
#(
  parameter int ZW = ZW_DEF,
  parameter int YW = YW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [ZW-1:0] in_z,
  input  logic [YW-1:0] in_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [ZW-1:0] out_q,
  output logic [YW-1:0] out_r,
  output logic          out_dz
);

  localparam int CW = cnt_width(ZW);
  localparam logic [CW-1:0] CNT_LAST = CW'(ZW - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [YW:0]   rem;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after ZW steps this register holds the quotient.
  logic [ZW-1:0] zq;
  logic [YW-1:0] y_q;

  logic [YW:0]   step_rem;
  logic          step_q;

  lenet_xwyf_div_step #(.YW(YW)) u_step (
    .rem_in  (rem),
    .bit_in  (zq[ZW-1]),
    .y       (y_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Handshake flags are pure state decodes.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // FSM, step counter, working registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rem    <= '0;
      zq     <= '0;
      y_q    <= '0;
      out_q  <= '0;
      out_r  <= '0;
      out_dz <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            zq  <= in_z;
            y_q <= in_y;
            rem <= '0;
            cnt <= '0;
            if (in_y == '0) begin
              out_q  <= '1;
              out_r  <= in_z[YW-1:0];
              out_dz <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          rem <= step_rem;
          zq  <= {zq[ZW-2:0], step_q};
          if (cnt == CNT_LAST) begin
            // Results update only on the final step so no partial value is exposed.
            out_q  <= {zq[ZW-2:0], step_q};
            out_r  <= step_rem[YW-1:0];
            out_dz <= 1'b0;
            state  <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lenet_xwyf_udiv.sv
// Purpose: self-checking bench for lenet_xwyf_udiv (directed cases, reset abort, random stalls).
// Latency: checks ZW-step latency for y!=0 and single-cycle result for y==0.
// Backpressure: exercises held outputs under out_ready stalls and random ready patterns.
module tb_lenet_xwyf_udiv;

  localparam int ZW = 16;
  localparam int YW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [ZW-1:0] in_z;
  logic [YW-1:0] in_y;
  logic          out_valid;
  logic          out_ready;
  logic [ZW-1:0] out_q;
  logic [YW-1:0] out_r;
  logic          out_dz;

  logic rdy_force;
  logic rand_mode;
  logic rnd_rdy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [24:0] sb[$];
  logic        hold_vld;
  logic [24:0] held;

  assign out_ready = rand_mode ? rnd_rdy : rdy_force;

  lenet_xwyf_udiv #(.ZW(ZW), .YW(YW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z      (in_z),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_dz    (out_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [24:0] model(input logic [ZW-1:0] z, input logic [YW-1:0] y);
    logic [ZW-1:0] q;
    logic [ZW-1:0] r;
    if (y == '0) return {16'hFFFF, z[YW-1:0], 1'b1};
    q = z / {8'h00, y};
    r = z % {8'h00, y};
    return {q, r[YW-1:0], 1'b0};
  endfunction

  // Random ready pattern, used only while rand_mode is set.
  initial begin
    rnd_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard: push expected on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    logic [24:0] exp;
    if (!rst_n) begin
      sb.delete();
      hold_vld = 1'b0;
    end else begin
      if (hold_vld && out_valid)
        chk("held_outputs", 32'({out_q, out_r, out_dz}), 32'(held));
      hold_vld = out_valid && !out_ready;
      held     = {out_q, out_r, out_dz};
      if (out_valid && out_ready) begin
        exp = 'x;
        if (sb.size() > 0) exp = sb.pop_front();
        chk("result", 32'({out_q, out_r, out_dz}), 32'(exp));
      end
      if (in_valid && in_ready) sb.push_back(model(in_z, in_y));
    end
  end

  // Present operands until accepted, then scramble them to show they are ignored.
  task automatic send(input logic [ZW-1:0] z, input logic [YW-1:0] y);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_z     = z;
    in_y     = y;
    for (int i = 0; i < 400; i++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    chk("accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    in_z     = ZW'($urandom);
    in_y     = YW'($urandom);
  endtask

  // One division with out_ready high: latency, constant results, release of in_ready.
  task automatic do_div(input logic [ZW-1:0] z, input logic [YW-1:0] y,
                        input logic [ZW-1:0] eq, input logic [YW-1:0] er,
                        input logic edz, input int elat);
    int n;
    send(z, y);
    // Stray request while busy must be ignored.
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(n), 32'(elat));
    chk("q", 32'(out_q), 32'(eq));
    chk("r", 32'(out_r), 32'(er));
    chk("dz", 32'(out_dz), 32'(edz));
    @(posedge clk);
    #1;
    chk("valid_after_hs", 32'(out_valid), 32'd0);
    chk("ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_z      = '0;
    in_y      = '0;
    rdy_force = 1'b1;
    rand_mode = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(out_q), 32'd0);
    chk("rst_r", 32'(out_r), 32'd0);
    chk("rst_dz", 32'(out_dz), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Main function and boundaries.
    do_div(16'd12345, 8'd123, 16'd100, 8'd45, 1'b0, 16);
    do_div(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 16);
    do_div(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 16);
    do_div(16'd65025, 8'd255, 16'd255, 8'd0, 1'b0, 16);
    do_div(16'd100, 8'd0, 16'hFFFF, 8'h64, 1'b1, 0);
    do_div(16'd0, 8'd9, 16'd0, 8'd0, 1'b0, 16);

    // Output stall: result and in_ready held while out_ready is low.
    rdy_force = 1'b0;
    send(16'd1000, 8'd7);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_q", 32'(out_q), 32'd142);
      chk("stall_r", 32'(out_r), 32'd6);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rdy_force = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_valid", 32'(out_valid), 32'd0);
    chk("stall_release_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset while stepping (cnt==8): everything back to reset values.
    send(16'd40000, 8'd200);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_q", 32'(out_q), 32'd0);
    chk("arst_r", 32'(out_r), 32'd0);
    chk("arst_dz", 32'(out_dz), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_div(16'd50, 8'd7, 16'd7, 8'd1, 1'b0, 16);

    // Random operands with random input gaps and output stalls.
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(ZW'($urandom), YW'($urandom_range(1, 255)));
    end
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    chk("final_in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
